exu_seq_ctrl: RTL

Multi-cycle sequencer for the single-issue NPC core. Owns the architectural PC and the instruction register, and steps each instruction through fetch, decode/execute, optional memory access and write-back. Drives the IFU and LSU request handshakes, gates register-file writes, and stops the core on `ebreak`, bus error or response timeout. The instruction register feeds `exu_decode`; decoded flags and branch results return combinationally during EXEC.

---
 rtl/exu_seq_ctrl_pkg.sv | 27 ++
 rtl/seq_tmo_cnt.sv | 30 +++
 rtl/exu_seq_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/exu_seq_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
// State encoding, timeout counter width and the nop used to seed the instruction register.
package exu_seq_ctrl_pkg;

  localparam int PC_SIZE       = 32;
  localparam int INSTR_SIZE    = 32;
  localparam int SEQ_TMO_WIDTH = 8;

  // addi x0, x0, 0
  localparam logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    SEQ_ST_FETCH_REQ  = 3'd0,
    SEQ_ST_FETCH_WAIT = 3'd1,
    SEQ_ST_EXEC       = 3'd2,
    SEQ_ST_MEM_REQ    = 3'd3,
    SEQ_ST_MEM_WAIT   = 3'd4,
    SEQ_ST_WB         = 3'd5,
    SEQ_ST_HALT       = 3'd6,
    SEQ_ST_FAULT      = 3'd7
  } seq_state_e;

  function automatic logic pc_misaligned(input logic [PC_SIZE-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/seq_tmo_cnt.sv
// Response timeout counter shared by the fetch and memory wait phases.
// hit flags the last permitted wait cycle, so a missing response there means timeout.
module seq_tmo_cnt
  import exu_seq_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [SEQ_TMO_WIDTH-1:0] HIT_VAL = SEQ_TMO_WIDTH'(TMO_CYC - 1);

  logic [SEQ_TMO_WIDTH-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + SEQ_TMO_WIDTH'(1);
    end
  end

  assign hit = (cnt == HIT_VAL);

endmodule

// File: rtl/exu_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC and IR, drives IFU/LSU handshakes,
// gates register-file writes and retires or stops the core.
module exu_seq_ctrl
  import exu_seq_ctrl_pkg::*;
#(
  parameter logic [PC_SIZE-1:0] PC_RESET = 32'h8000_0000,
  parameter int unsigned        TMO_CYC  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  input  logic                  ifu_rsp_err,
  output logic [INSTR_SIZE-1:0] ir,
  output logic [PC_SIZE-1:0]    ir_pc,
  input  logic                  dec_ldst,
  input  logic                  dec_bjp,
  input  logic                  dec_ebreak,
  input  logic                  dec_rdwen,
  input  logic                  bjp_taken,
  input  logic [PC_SIZE-1:0]    bjp_target,
  output logic                  lsu_req_valid,
  input  logic                  lsu_req_ready,
  input  logic                  lsu_rsp_valid,
  input  logic                  lsu_rsp_err,
  output logic                  rf_wen,
  output logic                  commit_valid,
  output logic [PC_SIZE-1:0]    commit_pc,
  output logic                  halt,
  output logic                  fault
);

  seq_state_e         state, state_nxt;
  logic [PC_SIZE-1:0] pc;
  logic [PC_SIZE-1:0] next_pc_q;
  logic [PC_SIZE-1:0] next_pc_calc;
  logic               rdwen_q;
  logic               misal_q;
  logic               halt_commit_q;
  logic               tmo_clr;
  logic               tmo_en;
  logic               tmo_hit;

  seq_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo_cnt (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .hit (tmo_hit)
  );

  assign next_pc_calc = (dec_bjp && bjp_taken) ? bjp_target : pc + PC_SIZE'(4);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    unique case (state)
      SEQ_ST_FETCH_REQ: begin
        if (ifu_req_ready) begin
          state_nxt = SEQ_ST_FETCH_WAIT;
          tmo_clr   = 1'b1;
        end
      end
      // A response in the timeout cycle still wins; err beats data.
      SEQ_ST_FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          state_nxt = ifu_rsp_err ? SEQ_ST_FAULT : SEQ_ST_EXEC;
        end else if (tmo_hit) begin
          state_nxt = SEQ_ST_FAULT;
        end else begin
          tmo_en = 1'b1;
        end
      end
      SEQ_ST_EXEC: begin
        if (dec_ebreak) begin
          state_nxt = SEQ_ST_HALT;
        end else if (dec_ldst) begin
          state_nxt = SEQ_ST_MEM_REQ;
        end else begin
          state_nxt = SEQ_ST_WB;
        end
      end
      SEQ_ST_MEM_REQ: begin
        if (lsu_req_ready) begin
          state_nxt = SEQ_ST_MEM_WAIT;
          tmo_clr   = 1'b1;
        end
      end
      SEQ_ST_MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          state_nxt = lsu_rsp_err ? SEQ_ST_FAULT : SEQ_ST_WB;
        end else if (tmo_hit) begin
          state_nxt = SEQ_ST_FAULT;
        end else begin
          tmo_en = 1'b1;
        end
      end
      SEQ_ST_WB: begin
        state_nxt = misal_q ? SEQ_ST_FAULT : SEQ_ST_FETCH_REQ;
      end
      SEQ_ST_HALT:  state_nxt = SEQ_ST_HALT;
      SEQ_ST_FAULT: state_nxt = SEQ_ST_FAULT;
    endcase
  end

  // Decoder results are captured in EXEC so WB outputs never depend on live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SEQ_ST_FETCH_REQ;
      pc            <= PC_RESET;
      ir            <= NOP_INSTR;
      ir_pc         <= PC_RESET;
      next_pc_q     <= PC_RESET;
      rdwen_q       <= 1'b0;
      misal_q       <= 1'b0;
      halt_commit_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      halt_commit_q <= (state == SEQ_ST_EXEC) && dec_ebreak;
      if (state == SEQ_ST_FETCH_WAIT && ifu_rsp_valid && !ifu_rsp_err) begin
        ir    <= ifu_rsp_instr;
        ir_pc <= pc;
      end
      if (state == SEQ_ST_EXEC) begin
        next_pc_q <= next_pc_calc;
        rdwen_q   <= dec_rdwen;
        misal_q   <= pc_misaligned(next_pc_calc);
      end
      if (state == SEQ_ST_WB && !misal_q) begin
        pc <= next_pc_q;
      end
    end
  end

  assign ifu_req_valid = (state == SEQ_ST_FETCH_REQ);
  assign ifu_req_addr  = pc;
  assign lsu_req_valid = (state == SEQ_ST_MEM_REQ);
  assign rf_wen        = (state == SEQ_ST_WB) && rdwen_q && !misal_q;
  assign commit_valid  = ((state == SEQ_ST_WB) && !misal_q) || halt_commit_q;
  assign commit_pc     = ir_pc;
  assign halt          = (state == SEQ_ST_HALT);
  assign fault         = (state == SEQ_ST_FAULT);

endmodule
